instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the control unit / decoder: owns the PC, reads 32-bit words from

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared instruction field slices, fetch FSM states and opcode constants
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIR} fetch_state_e;
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] i);
    return i[OPCODE_MSB:OPCODE_LSB];
  endfunction
  function automatic logic [5:0] funct_of(input logic [INSTR_W-1:0] i);
    return i[FUNCT_MSB:FUNCT_LSB];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of {pc,instr} with push/pop/flush (flush beats push), count, full/empty
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push_en, pop_en;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
  always_comb begin
    push_en = push && !flush && (!full || pop);
    pop_en = pop && !empty;
    mem_d = mem_q;
    if (push_en) mem_d[wr_q] = wdata;
    rd_d = flush ? '0 : rd_q + PW'(pop_en);
    wr_d = flush ? '0 : wr_q + PW'(push_en);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + imem prefetch into fetch_fifo with valid/ready output and branch/jump redirect; FETCH_PERF_EN adds perf_fetched/perf_flushed counters
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, target;
  logic inflight_q, inflight_d, redirect, issue, pop, full, empty;
  logic [CW-1:0] count;
  logic [ADDR_W+INSTR_W-1:0] head;
  always_comb begin
    redirect = jump || branch_taken;
    target = (jump ? jump_target : branch_target) & ~ADDR_W'(3);
    pop = !empty && instr_ready;
    issue = state_q == S_RUN && !redirect && (!full || pop) &&
            ((CW+1)'(count) + (CW+1)'(inflight_q) < (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
    state_d = redirect ? S_REDIR : S_RUN;
    pc_d = redirect ? target : issue ? pc_q + ADDR_W'(4) : pc_q;
    req_pc_d = issue ? pc_q : req_pc_q;
    inflight_d = issue;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end
  fetch_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight_q),
    .pop(pop),
    .flush(redirect),
    .wdata({req_pc_q, imem_rdata}),
    .rdata(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign imem_rd_en = issue;
  assign imem_addr = pc_q;
  assign instr_valid = !empty;
  assign instr = head[INSTR_W-1:0];
  assign pc_out = head[ADDR_W+INSTR_W-1:INSTR_W];
  assign opcode = opcode_of(instr);
  assign funct = funct_of(instr);
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_flushed_d = redirect ? perf_flushed_q + 32'(count) - 32'(pop) + 32'(inflight_q) : perf_flushed_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed cycle-by-cycle checks of fetch timing, stall, redirect, wrap and reset
module tb_instr_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, instr_ready = 1'b1, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] imem_rdata = '0, branch_target = '0, jump_target = '0;
  logic imem_rd_en, instr_valid;
  logic [31:0] imem_addr, instr, pc_out;
  logic [5:0] opcode, funct;
  int nerr = 0, nchk = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] iw(input logic [31:0] a);
    return {a[7:2], 20'hABCDE, ~a[7:2]};
  endfunction
  always @(posedge clk) if (imem_rd_en) imem_rdata <= iw(imem_addr);
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    logic [5:0] op, fn;
    op = pc[7:2];
    fn = ~pc[7:2];
    chk({tag, "_valid"}, {31'b0, instr_valid}, 1);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_instr"}, instr, iw(pc));
    chk({tag, "_opcode"}, {26'b0, opcode}, {26'b0, op});
    chk({tag, "_funct"}, {26'b0, funct}, {26'b0, fn});
  endtask
  task automatic req(input string tag, input logic en, input logic [31:0] a);
    chk({tag, "_rd_en"}, {31'b0, imem_rd_en}, {31'b0, en});
    if (en) chk({tag, "_addr"}, imem_addr, a);
  endtask
  task automatic empty_chk(input string tag);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 0);
  endtask
  initial begin
    tick; tick; #1;
    empty_chk("rst"); req("rst", 0, 0);
    chk("rst_addr", imem_addr, 0); chk("rst_instr", instr, 0); chk("rst_pc", pc_out, 0);
    reset = 1'b0; #1;
    req("c0", 0, 0); empty_chk("c0");
    tick; #1; req("c1", 1, 32'h0); empty_chk("c1");
    tick; #1; req("c2", 1, 32'h4); empty_chk("c2");
    tick; #1; head("c3", 32'h0); req("c3", 1, 32'h8);
    tick; #1; head("c4", 32'h4);
    tick; #1; head("c5", 32'h8);
    tick; #1; head("c6", 32'hC);
    tick; instr_ready = 1'b0; #1; head("c7", 32'h10); req("c7", 0, 0);
    for (int i = 8; i < 12; i++) begin
      tick; #1; head("stall", 32'h10); req("stall", 0, 0);
    end
    tick; instr_ready = 1'b1; #1; head("c12", 32'h10); req("c12", 1, 32'h18);
    tick; #1; head("c13", 32'h14); req("c13", 1, 32'h1C);
    tick; #1; head("c14", 32'h18);
    tick; jump = 1'b1; jump_target = 32'h43; #1; head("c15", 32'h1C); req("c15", 0, 0);
    tick; jump = 1'b0; #1; empty_chk("c16"); req("c16", 0, 0); chk("c16_addr", imem_addr, 32'h40);
    tick; #1; empty_chk("c17"); req("c17", 1, 32'h40);
    tick; #1; empty_chk("c18"); req("c18", 1, 32'h44);
    tick; #1; head("c19", 32'h40);
    tick; jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h80; #1;
    head("c20", 32'h44); req("c20", 0, 0);
    tick; jump = 1'b0; branch_taken = 1'b0; #1; empty_chk("c21"); chk("c21_addr", imem_addr, 32'h100);
    tick; #1; req("c22", 1, 32'h100);
    tick; tick; #1; head("c24", 32'h100);
    tick; jump = 1'b1; jump_target = 32'h300; #1; req("c25", 0, 0);
    tick; jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h200; #1;
    req("c26", 0, 0); chk("c26_addr", imem_addr, 32'h300); empty_chk("c26");
    tick; branch_taken = 1'b0; #1; req("c27", 0, 0); chk("c27_addr", imem_addr, 32'h200); empty_chk("c27");
    tick; #1; req("c28", 1, 32'h200);
    tick; tick; #1; head("c30", 32'h200);
    tick; jump = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
    tick; jump = 1'b0; #1;
    tick; #1; req("c33", 1, 32'hFFFF_FFFC);
    tick; #1; req("wrap", 1, 32'h0);
    tick; #1; head("c35", 32'hFFFF_FFFC);
    tick; #1; head("c36", 32'h0);
    tick; instr_ready = 1'b0; #1;
    tick; #1;
    tick; #1; head("full", 32'h4); req("full", 0, 0);
    reset = 1'b1;
    tick; #1; empty_chk("mrst"); req("mrst", 0, 0);
    chk("mrst_addr", imem_addr, 32'h0); chk("mrst_instr", instr, 0);
    reset = 1'b0; instr_ready = 1'b1;
`ifdef FETCH_PERF_EN
    chk("perf_rst_fetched", perf_fetched, 0); chk("perf_rst_flushed", perf_flushed, 0);
`endif
    tick; tick; tick; #1; head("p3", 32'h0);
    for (int i = 4; i < 13; i++) tick;
    #1; head("p12", 32'h24);
    tick; instr_ready = 1'b0; #1; head("p13", 32'h28); req("p13", 0, 0);
    tick; #1; head("p14", 32'h28); req("p14", 0, 0);
    jump = 1'b1; jump_target = 32'h40; #1; req("p14_redir", 0, 0);
    tick; jump = 1'b0; #1; empty_chk("p15");
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 10); chk("perf_flushed2", perf_flushed, 2);
`endif
    tick; #1; req("p16", 1, 32'h40);
    tick; jump = 1'b1; jump_target = 32'h80; #1; empty_chk("p17"); req("p17", 0, 0);
    tick; jump = 1'b0; #1; empty_chk("p18"); chk("p18_addr", imem_addr, 32'h80);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_hold", perf_fetched, 10); chk("perf_flushed3", perf_flushed, 3);
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
